// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: shared types and constants for the keypad matrix scanner.
//   state_e  - scan FSM states
//   key_w()  - width of a key index for a ROWS x COLS matrix
//   RST_*    - reset values of the scalar FSM outputs
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_NEXT   = 3'd4
  } state_e;

  localparam state_e RST_STATE     = ST_IDLE;
  localparam logic   RST_EVT_VALID = 1'b0;
  localparam logic   RST_EVT_PRESS = 1'b0;

  // Width of a key index; never narrower than one bit.
  function automatic int key_w(input int rows, input int cols);
    int n;
    n = rows * cols;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_evt_if: press/release event channel with valid/ready handshake.
//   valid - event available (producer)
//   ready - consumer accepts when valid & ready
//   key   - key index = row*COLS + col
//   press - 1 = press, 0 = release
interface keypad_evt_if #(parameter int KEY_W = 4);

  logic             valid;
  logic             ready;
  logic [KEY_W-1:0] key;
  logic             press;

  modport master (output valid, output key, output press, input ready);
  modport slave  (input valid, input key, input press, output ready);

endinterface

// File: rtl/keypad_scanner_col_sync.sv
// col_sync: W-bit two-flop synchronizer for the asynchronous column inputs.
//   clk, rst - clock, asynchronous active-high reset (flops reset to all ones,
//              i.e. "no key pressed" for active-low columns)
//   d        - asynchronous input
//   q        - synchronized output
module col_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] meta_d;
  logic [W-1:0] sync_q;
  logic [W-1:0] sync_d;

  // Next values of the two synchronizer stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a ROWS x COLS key matrix one row at a time, debounces
// each row over DEB_SCANS identical frames and reports every key change as a
// press/release event.
//   clk, rst - clock, asynchronous active-high reset
//   scan_en  - 1 = scan continuously, 0 = park after the current row
//   row_n    - active-low one-hot row drive (all ones when parked)
//   col_n    - asynchronous active-low column sense
//   evt      - event channel (master side)
//   keys     - debounced key map, bit row*COLS+col = 1 when pressed
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int SETTLE_BITS = 4,
  parameter int DEB_SCANS   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_en,
  output logic [ROWS-1:0]      row_n,
  input  logic [COLS-1:0]      col_n,
  keypad_evt_if.master         evt,
  output logic [ROWS*COLS-1:0] keys
);

  localparam int KEY_W = key_w(ROWS, COLS);
  localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;
  localparam logic [CNT_W-1:0]       CNT_MAX    = CNT_W'(DEB_SCANS - 1);
  localparam logic [SETTLE_BITS-1:0] SETTLE_MAX = {SETTLE_BITS{1'b1}};

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [SETTLE_BITS-1:0] settle_q, settle_d;
  logic [COLS-1:0]        cand_q [ROWS];
  logic [COLS-1:0]        cand_d [ROWS];
  logic [CNT_W-1:0]       cnt_q  [ROWS];
  logic [CNT_W-1:0]       cnt_d  [ROWS];
  logic [ROWS*COLS-1:0]   keys_q, keys_d;
  logic [ROWS-1:0]        row_n_q, row_n_d;
  logic                   evt_valid_q, evt_valid_d;
  logic [KEY_W-1:0]       evt_key_q, evt_key_d;
  logic                   evt_press_q, evt_press_d;

  logic [COLS-1:0]  col_sync_s;
  logic [COLS-1:0]  sample_s;
  logic [COLS-1:0]  cand_row_s;
  logic [CNT_W-1:0] cnt_row_s;
  logic [CNT_W-1:0] cnt_upd_s;
  logic [COLS-1:0]  keys_row_s;
  logic [COLS-1:0]  diff_s;
  logic [COL_W-1:0] col_idx_s;
  logic [KEY_W-1:0] key_idx_s;
  logic [PTR_W-1:0] next_ptr_s;
  logic [ROWS-1:0]  cur_row_n_s;
  logic [ROWS-1:0]  nxt_row_n_s;
  logic [ROWS-1:0]  adv_row_n_s;
  state_e           adv_state_s;
  logic             stable_s;

  col_sync #(.W(COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_sync_s)
  );

  // Views of the current row: sample, candidate, count, accepted keys, row drives.
  always_comb begin
    sample_s    = ~col_sync_s;
    cand_row_s  = cand_q[ptr_q];
    cnt_row_s   = cnt_q[ptr_q];
    next_ptr_s  = (ptr_q == PTR_W'(ROWS - 1)) ? '0 : ptr_q + PTR_W'(1);
    keys_row_s  = '0;
    cur_row_n_s = '1;
    nxt_row_n_s = '1;
    for (int r = 0; r < ROWS; r++) begin
      keys_row_s     = keys_row_s | ((PTR_W'(r) == ptr_q) ? keys_q[r*COLS +: COLS] : '0);
      cur_row_n_s[r] = (PTR_W'(r) != ptr_q);
      nxt_row_n_s[r] = (PTR_W'(r) != next_ptr_s);
    end
    adv_state_s = scan_en ? ST_DRIVE : ST_IDLE;
    adv_row_n_s = scan_en ? nxt_row_n_s : '1;
  end

  // Debounce update: count identical samples, restart on any difference.
  always_comb begin
    cnt_upd_s = (sample_s != cand_row_s) ? '0 :
                (cnt_row_s == CNT_MAX)   ? CNT_MAX : cnt_row_s + CNT_W'(1);
    stable_s  = (cnt_upd_s == CNT_MAX);
  end

  // Lowest differing column of the accepted candidate and its key index.
  always_comb begin
    diff_s    = cand_row_s ^ keys_row_s;
    col_idx_s = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      col_idx_s = diff_s[c] ? COL_W'(c) : col_idx_s;
    end
    key_idx_s = KEY_W'(ptr_q) * KEY_W'(COLS) + KEY_W'(col_idx_s);
  end

  // Scan FSM next-state logic. SAMPLE advances straight to the next row when
  // there is nothing to report so the row period stays 2**SETTLE_BITS+1.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    settle_d    = settle_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    keys_d      = keys_q;
    row_n_d     = row_n_q;
    evt_valid_d = evt_valid_q;
    evt_key_d   = evt_key_q;
    evt_press_d = evt_press_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_en) begin
          state_d  = ST_DRIVE;
          settle_d = '0;
          row_n_d  = cur_row_n_s;
        end else begin
          row_n_d  = '1;
        end
      end
      ST_DRIVE: begin
        if (settle_q == SETTLE_MAX) begin
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + SETTLE_BITS'(1);
        end
      end
      ST_SAMPLE: begin
        cand_d[ptr_q] = sample_s;
        cnt_d[ptr_q]  = cnt_upd_s;
        if (stable_s && (sample_s != keys_row_s)) begin
          state_d  = ST_EMIT;
        end else begin
          ptr_d    = next_ptr_s;
          state_d  = adv_state_s;
          settle_d = '0;
          row_n_d  = adv_row_n_s;
        end
      end
      ST_EMIT: begin
        // Load on a free slot or in the handshake cycle (back-to-back).
        if (!evt_valid_q || evt.ready) begin
          if (|diff_s) begin
            evt_valid_d       = 1'b1;
            evt_key_d         = key_idx_s;
            evt_press_d       = cand_row_s[col_idx_s];
            keys_d[key_idx_s] = cand_row_s[col_idx_s];
          end else begin
            evt_valid_d       = 1'b0;
            state_d           = ST_NEXT;
          end
        end else begin
          evt_valid_d = evt_valid_q;
        end
      end
      ST_NEXT: begin
        ptr_d    = next_ptr_s;
        state_d  = adv_state_s;
        settle_d = '0;
        row_n_d  = adv_row_n_s;
      end
      default: begin
        state_d     = ST_IDLE;
        row_n_d     = '1;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      ptr_q       <= '0;
      settle_q    <= '0;
      keys_q      <= '0;
      row_n_q     <= '1;
      evt_valid_q <= RST_EVT_VALID;
      evt_key_q   <= '0;
      evt_press_q <= RST_EVT_PRESS;
      for (int r = 0; r < ROWS; r++) begin
        cand_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      settle_q    <= settle_d;
      keys_q      <= keys_d;
      row_n_q     <= row_n_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
      evt_press_q <= evt_press_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
    end
  end

  assign row_n     = row_n_q;
  assign keys      = keys_q;
  assign evt.valid = evt_valid_q;
  assign evt.key   = evt_key_q;
  assign evt.press = evt_press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner (4x4, settle 4
// cycles, 3-frame debounce). A behavioural matrix drives col_n from the
// pressed-key map and row_n; expected events go into a scoreboard queue when
// keys are changed and are compared as handshakes occur.
module tb_keypad_scanner;

  typedef struct packed {
    logic [3:0]  key;
    logic        press;
    logic [15:0] keys;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keys;
  logic [15:0] pressed;
  logic [15:0] model_keys;
  evt_t        sb_q [$];
  int          checks = 0;
  int          failures = 0;

  keypad_evt_if #(.KEY_W(4)) evt_if ();

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SETTLE_BITS(2), .DEB_SCANS(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .scan_en (scan_en),
    .row_n   (row_n),
    .col_n   (col_n),
    .evt     (evt_if),
    .keys    (keys)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  // Change one key in the matrix and queue the event the scanner must report.
  task automatic set_key(input int k, input logic p);
    evt_t e;
    pressed[k]    = p;
    model_keys[k] = p;
    e.key   = 4'(k);
    e.press = p;
    e.keys  = model_keys;
    sb_q.push_back(e);
  endtask

  // One clock: observe at the falling edge (scoreboard on handshakes), return #1 after rising edge.
  task automatic tick();
    evt_t e;
    @(negedge clk);
    if (evt_if.valid && evt_if.ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got key=%0d press=%0b expected no event", evt_if.key, evt_if.press);
      end else begin
        e = sb_q.pop_front();
        if (evt_if.key !== e.key || evt_if.press !== e.press || keys !== e.keys) begin
          failures++;
          $display("FAIL sb_event got key=%0d press=%0b keys=%h expected key=%0d press=%0b keys=%h",
                   evt_if.key, evt_if.press, keys, e.key, e.press, e.keys);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Return just after the edge on which row_n first shows pat.
  task automatic wait_row(input logic [3:0] pat);
    logic [3:0] prev;
    bit         found;
    prev  = row_n;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (row_n == pat && prev != pat) found = 1'b1;
      prev = row_n;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_row timeout got row_n=%h expected %h", row_n, pat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_en = 1'b0; evt_if.ready = 1'b1;
    pressed = '0; model_keys = '0;
    run(3);
    checks++;
    if (row_n !== 4'hF || evt_if.valid !== 1'b0 || evt_if.key !== 4'd0 ||
        evt_if.press !== 1'b0 || keys !== 16'h0) begin
      failures++;
      $display("FAIL reset got row_n=%h valid=%b key=%0d press=%b keys=%h expected F 0 0 0 0000",
               row_n, evt_if.valid, evt_if.key, evt_if.press, keys);
    end
    rst = 1'b0;
    run(3);
    checks++;
    if (row_n !== 4'hF) begin
      failures++;
      $display("FAIL idle_parked got row_n=%h expected F", row_n);
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] pat [4];
    pat[0] = 4'hE; pat[1] = 4'hD; pat[2] = 4'hB; pat[3] = 4'h7;
    scan_en = 1'b1;
    for (int m = 1; m <= 40; m++) begin
      tick();
      checks++;
      if (row_n !== pat[((m - 1) / 5) % 4]) begin
        failures++;
        $display("FAIL idle_scan cycle %0d got row_n=%h expected %h", m, row_n, pat[((m - 1) / 5) % 4]);
      end
    end
  endtask

  task automatic test_press_release();
    int got;
    wait_row(4'hD);
    set_key(6, 1'b1);
    got = -1;
    for (int m = 1; m <= 80 && got < 0; m++) begin
      tick();
      if (evt_if.valid) got = m;
    end
    checks++;
    if (got != 46) begin
      failures++;
      $display("FAIL press_latency got %0d cycles expected 46", got);
    end
    run(30);
    checks++;
    if (keys !== 16'h0040 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL press_keys got keys=%h pending=%0d expected 0040 0", keys, sb_q.size());
    end
    set_key(6, 1'b0);
    run(100);
    checks++;
    if (keys !== 16'h0000 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL release_keys got keys=%h pending=%0d expected 0000 0", keys, sb_q.size());
    end
  endtask

  task automatic test_bounce();
    wait_row(4'hD);
    pressed[6] = 1'b1;
    wait_row(4'hD);
    pressed[6] = 1'b0;
    run(100);
    checks++;
    if (keys !== 16'h0000) begin
      failures++;
      $display("FAIL bounce_keys got keys=%h expected 0000", keys);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    evt_if.ready = 1'b0;
    set_key(4, 1'b1);
    set_key(5, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (evt_if.valid) seen = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (evt_if.valid !== 1'b1 || evt_if.key !== 4'd4 || evt_if.press !== 1'b1 || row_n !== 4'hD) begin
        failures++;
        $display("FAIL stall got valid=%b key=%0d press=%b row_n=%h expected 1 4 1 D",
                 evt_if.valid, evt_if.key, evt_if.press, row_n);
      end
    end
    evt_if.ready = 1'b1;
    tick();
    checks++;
    if (evt_if.valid !== 1'b1 || evt_if.key !== 4'd5 || keys !== 16'h0030) begin
      failures++;
      $display("FAIL b2b_second got valid=%b key=%0d keys=%h expected 1 5 0030",
               evt_if.valid, evt_if.key, keys);
    end
    run(30);
    checks++;
    if (sb_q.size() != 0 || row_n === 4'hD) begin
      failures++;
      $display("FAIL b2b_resume got pending=%0d row_n=%h expected 0 and scan moved on", sb_q.size(), row_n);
    end
    set_key(4, 1'b0);
    set_key(5, 1'b0);
    run(100);
    checks++;
    if (keys !== 16'h0000 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_release got keys=%h pending=%0d expected 0000 0", keys, sb_q.size());
    end
  endtask

  task automatic test_scan_stop();
    set_key(0, 1'b1);
    run(100);
    wait_row(4'hB);
    scan_en = 1'b0;
    for (int m = 1; m <= 14; m++) begin
      tick();
      checks++;
      if (row_n !== ((m <= 4) ? 4'hB : 4'hF)) begin
        failures++;
        $display("FAIL scan_stop cycle %0d got row_n=%h expected %h", m, row_n, (m <= 4) ? 4'hB : 4'hF);
      end
    end
    checks++;
    if (keys !== 16'h0001 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL scan_stop_keys got keys=%h pending=%0d expected 0001 0", keys, sb_q.size());
    end
  endtask

  task automatic test_reset_mid_emit();
    bit seen;
    scan_en = 1'b1;
    evt_if.ready = 1'b0;
    pressed[15] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (evt_if.valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL emit_timeout got valid=%b expected 1", evt_if.valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (row_n !== 4'hF || evt_if.valid !== 1'b0 || keys !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset got row_n=%h valid=%b keys=%h expected F 0 0000",
               row_n, evt_if.valid, keys);
    end
    pressed = '0;
    model_keys = '0;
    run(2);
    rst = 1'b0;
    evt_if.ready = 1'b1;
    scan_en = 1'b0;
    run(5);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_press_release();
    test_bounce();
    test_back_to_back();
    test_scan_stop();
    test_reset_mid_emit();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d pending events expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
